// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StRx
    } rx_ctrl_state_t;

    function automatic int unsigned cycles_per_bit(input int unsigned clk_freq,
                                                   input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO; the occupancy count decides full and empty.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              do_wr, do_rd;

    assign full_o  = (count_q == CountW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign do_rd = rd_i & ~empty_o;
    assign do_wr = wr_i & (~full_o | do_rd);

    // Empty head reads as zero so the output is defined without clearing storage.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CountW'(do_wr) - CountW'(do_rd);
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: gates the receiver, buffers bytes, flags overflow, detects line idle.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned IDLE_BITS  = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_i,
    input  logic                          rx_busy_i,
    input  logic                          rx_done_i,
    input  logic [7:0]                    rx_data_i,
    output logic                          rx_en_o,
    input  logic                          rd_en_i,
    output logic [7:0]                    rd_data_o,
    output logic                          fifo_empty_o,
    output logic                          fifo_full_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
    input  logic                          clr_overflow_i,
    output logic                          idle_timeout_o
);

    localparam int unsigned CyclesPerBit = cycles_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned IdleCycles   = IDLE_BITS * CyclesPerBit;
    localparam int unsigned CntW         = $clog2(IdleCycles);
    localparam int unsigned IdleMax      = IdleCycles - 1;

    rx_ctrl_state_t  state_q, state_d;
    logic            rx_done_q;
    logic            overflow_q, overflow_d;
    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
    logic            idle_armed_q, idle_armed_d;
    logic            idle_to_q, idle_to_d;
    logic            wr_stb;
    logic            drop;

    assign wr_stb = rx_done_i & ~rx_done_q;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (wr_stb),
        .wr_data_i (rx_data_i),
        .rd_i      (rd_en_i),
        .rd_data_o (rd_data_o),
        .full_o    (fifo_full_o),
        .empty_o   (fifo_empty_o),
        .count_o   (fifo_count_o)
    );

    // A byte is lost only when full and no pop frees a slot this cycle.
    assign drop = wr_stb & fifo_full_o & ~(rd_en_i & ~fifo_empty_o);

    // Once a frame starts, the receiver stays enabled until it ends, even if software disables.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (rx_busy_i) begin
                    state_d = StRx;
                end else if (!enable_i) begin
                    state_d = StIdle;
                end
            end
            StRx: begin
                if (!rx_busy_i) begin
                    state_d = enable_i ? StArmed : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_en_o = (state_q != StIdle);

    always_comb begin
        overflow_d = (overflow_q & ~clr_overflow_i) | drop;
    end

    always_comb begin
        idle_cnt_d   = idle_cnt_q;
        idle_armed_d = idle_armed_q;
        idle_to_d    = 1'b0;
        if (state_q == StIdle || state_d == StIdle) begin
            idle_cnt_d   = '0;
            idle_armed_d = 1'b0;
        end else if (wr_stb) begin
            idle_cnt_d   = '0;
            idle_armed_d = 1'b1;
        end else if (rx_busy_i) begin
            idle_cnt_d = '0;
        end else if (idle_armed_q) begin
            if (idle_cnt_q == CntW'(IdleMax)) begin
                idle_to_d    = 1'b1;
                idle_armed_d = 1'b0;
                idle_cnt_d   = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + CntW'(1);
            end
        end
    end

    assign overflow_o     = overflow_q;
    assign idle_timeout_o = idle_to_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rx_done_q    <= 1'b0;
            overflow_q   <= 1'b0;
            idle_cnt_q   <= '0;
            idle_armed_q <= 1'b0;
            idle_to_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_done_q    <= rx_done_i;
            overflow_q   <= overflow_d;
            idle_cnt_q   <= idle_cnt_d;
            idle_armed_q <= idle_armed_d;
            idle_to_q    <= idle_to_d;
        end
    end

endmodule
